// File: rtl/apb_slave_mem.sv
// APB3 slave RAM: word-addressed storage with fixed wait states, range/alignment error
// responses, saturating transfer counters and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              hreset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              proto_err
);

    localparam int unsigned IdxW      = $clog2(DEPTH);
    localparam logic [63:0] SpanBytes = 64'(DEPTH) << 2;
    localparam logic [2:0]  WaitInit  = 3'(WAIT_STATES);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                valid_q, valid_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic                proto_err_q, proto_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;

    logic [ADDR_W-1:0]   setup_off;
    logic                setup_valid;
    logic [IdxW-1:0]     setup_idx;
    logic                bus_changed;

    // Decode is done on the live address in the setup cycle; it equals the latched value.
    always_comb begin
        setup_off   = paddr - BASE_ADDR;
        setup_valid = (paddr >= BASE_ADDR) && (64'(setup_off) < SpanBytes) &&
                      (paddr[1:0] == 2'b00);
        setup_idx   = setup_off[IdxW+1:2];
        bus_changed = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        prdata_d    = prdata_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;

        case (state_q)
            StIdle: begin
                if (psel && penable) begin
                    proto_err_d = 1'b1;
                end else if (psel) begin
                    state_d = StAccess;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    valid_d = setup_valid;
                    idx_d   = setup_idx;
                    wcnt_d  = WaitInit;
                    if (!pwrite) begin
                        prdata_d = setup_valid ? mem_q[setup_idx] : '0;
                    end
                end
            end
            StAccess: begin
                if (psel && bus_changed) begin
                    proto_err_d = 1'b1;
                end
                if (!psel || !penable) begin
                    // Abort; a dropped penable is not a fresh setup.
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    state_d = StIdle;
                    if (valid_q && write_q) begin
                        mem_we     = 1'b1;
                        wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
                    end
                    if (valid_q && !write_q) begin
                        rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hreset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            prdata_q    <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            prdata_q    <= prdata_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        pready    = (state_q == StAccess) && (wcnt_q == 3'd0);
        pslverr   = pready && !valid_q;
        prdata    = prdata_q;
        wr_count  = wr_count_q;
        rd_count  = rd_count_q;
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 2 and 3 wait states) driven independently,
// checked against constant vectors and a word-array reference model.
module tb_apb_slave_mem;

    localparam logic [31:0] Base = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        hreset;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    wire  [31:0] prdata  [3];
    wire         pready  [3];
    wire         pslverr [3];
    wire  [15:0] wr_count [3];
    wire  [15:0] rd_count [3];
    wire         proto_err [3];

    apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h8000_0000),
                    .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .hreset(hreset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .wr_count(wr_count[0]), .rd_count(rd_count[0]),
        .proto_err(proto_err[0]));

    apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h8000_0000),
                    .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .hreset(hreset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .wr_count(wr_count[1]), .rd_count(rd_count[1]),
        .proto_err(proto_err[1]));

    apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h8000_0000),
                    .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .hreset(hreset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .wr_count(wr_count[2]), .rd_count(rd_count[2]),
        .proto_err(proto_err[2]));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: one word array and counters per instance.
    logic [31:0] mem_m [3][256];
    int unsigned exp_wr [3];
    int unsigned exp_rd [3];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= Base) && ((a - Base) < 32'd1024) && (a[1:0] == 2'b00);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
            exp_wr[d] = 0;
            exp_rd[d] = 0;
        end
    endtask

    task automatic model_xfer(input int d, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, output bit m_err, output logic [31:0] m_rd);
        bit ok;
        int idx;
        ok    = addr_ok(a);
        idx   = int'((a - Base) >> 2);
        m_err = !ok;
        m_rd  = '0;
        if (ok && wr) begin
            mem_m[d][idx] = wd;
            if (exp_wr[d] < 65535) exp_wr[d]++;
        end else if (ok) begin
            m_rd = mem_m[d][idx];
            if (exp_rd[d] < 65535) exp_rd[d]++;
        end
    endtask

    // One APB transfer; poke flips pwdata at that access cycle, drop releases psel/penable.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int poke, input int drop, output logic [31:0] rd, output bit err,
                        output int low, output bit done);
        rd = '0; err = 1'b0; low = 0; done = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        tick();
        penable[d] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke) pwdata[d] = ~wd;
            if (k == drop) begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                tick();
                break;
            end
            if (pready[d]) begin
                rd = prdata[d]; err = pslverr[d]; done = 1'b1;
                tick();
                break;
            end
            check("pslverr_without_pready", 32'(pslverr[d]), 32'd0);
            low++;
            tick();
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (drop == 0) check("xfer_completes", 32'(done), 32'd1);
    endtask

    task automatic do_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input int poke, output logic [31:0] rd, output bit err, output int low,
                           output bit m_err, output logic [31:0] m_rd);
        bit done;
        xfer(d, wr, a, wd, poke, 0, rd, err, low, done);
        m_err = 1'b0; m_rd = '0;
        if (done) model_xfer(d, wr, a, wd, m_err, m_rd);
    endtask

    task automatic check_idle_reset(input int d);
        check("rst_pready", 32'(pready[d]), 32'd0);
        check("rst_pslverr", 32'(pslverr[d]), 32'd0);
        check("rst_prdata", prdata[d], 32'd0);
        check("rst_wr_count", 32'(wr_count[d]), 32'd0);
        check("rst_rd_count", 32'(rd_count[d]), 32'd0);
        check("rst_proto_err", 32'(proto_err[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tab [9];
        logic [31:0] rd, m_rd, a, wd;
        bit          err, m_err, done, wr;
        int          low, d, sel;
        int unsigned t0;

        tab[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tab[1] = '{1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tab[2] = '{1'b1, 32'h8000_0400, 32'h1111_1111, 1'b1, 32'h0};
        tab[3] = '{1'b1, 32'h8000_0002, 32'h2222_2222, 1'b1, 32'h0};
        tab[4] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0};
        tab[5] = '{1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0};
        tab[6] = '{1'b1, 32'h8000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0};
        tab[7] = '{1'b0, 32'h8000_03FC, 32'h0,         1'b0, 32'h0BAD_F00D};
        tab[8] = '{1'b0, 32'h8000_0400, 32'h0,         1'b1, 32'h0};

        hreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end
        model_reset();
        tick();
        tick();
        hreset = 1'b0;
        for (int i = 0; i < 3; i++) check_idle_reset(i);

        // Zero-wait vectors: basic write/read, range, alignment and boundary words.
        for (int i = 0; i < 9; i++) begin
            do_xfer(0, tab[i].wr, tab[i].addr, tab[i].wdata, 0, rd, err, low, m_err, m_rd);
            check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(tab[i].exp_err));
            check($sformatf("vec%0d_wait", i), low, 0);
            if (!tab[i].wr) check($sformatf("vec%0d_prdata", i), rd, tab[i].exp_rdata);
            if (i == 1) begin
                check("basic_wr_count", 32'(wr_count[0]), 32'd1);
                check("basic_rd_count", 32'(rd_count[0]), 32'd1);
            end
        end
        check("vec_wr_count", 32'(wr_count[0]), 32'd2);
        check("vec_rd_count", 32'(rd_count[0]), 32'd3);
        check("vec_proto_clean", 32'(proto_err[0]), 32'd0);

        // Enable asserted straight from idle: flagged, nothing written.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h8000_0040; pwdata[0] = 32'h0000_0055;
        tick();
        psel[0] = 1'b0; penable[0] = 1'b0;
        check("idle_enable_proto", 32'(proto_err[0]), 32'd1);
        check("idle_enable_wr_count", 32'(wr_count[0]), 32'd2);
        do_xfer(0, 1'b0, 32'h8000_0040, 32'h0, 0, rd, err, low, m_err, m_rd);
        check("idle_enable_mem", rd, 32'd0);

        // Two-wait write abandoned on its first wait cycle.
        xfer(1, 1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 0, 1, rd, err, low, done);
        check("drop_proto", 32'(proto_err[1]), 32'd1);
        check("drop_wr_count", 32'(wr_count[1]), 32'd0);
        do_xfer(1, 1'b0, 32'h8000_0008, 32'h0, 0, rd, err, low, m_err, m_rd);
        check("drop_mem", rd, 32'd0);
        check("drop_read_wait", low, 2);

        // Three-wait write then read with pwdata disturbed mid-wait.
        t0 = cyc;
        do_xfer(2, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 0, rd, err, low, m_err, m_rd);
        check("ws3_write_cycles", cyc - t0, 32'd5);
        check("ws3_write_wait", low, 3);
        check("ws3_proto_before", 32'(proto_err[2]), 32'd0);
        do_xfer(2, 1'b0, 32'h8000_0020, 32'h0, 2, rd, err, low, m_err, m_rd);
        check("ws3_read_wait", low, 3);
        check("ws3_read_data", rd, 32'hCAFE_F00D);
        check("ws3_read_pslverr", 32'(err), 32'd0);
        check("ws3_poke_proto", 32'(proto_err[2]), 32'd1);
        check("ws3_rd_count", 32'(rd_count[2]), 32'd1);

        // Reset while a three-wait write is waiting.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h8000_0030; pwdata[2] = 32'h1234_5678;
        tick();
        penable[2] = 1'b1;
        tick();
        check("midwait_pready", 32'(pready[2]), 32'd0);
        hreset = 1'b1;
        tick();
        hreset = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        model_reset();
        check_idle_reset(2);
        check("midwait_other_proto", 32'(proto_err[1]), 32'd0);
        do_xfer(2, 1'b0, 32'h8000_0030, 32'h0, 0, rd, err, low, m_err, m_rd);
        check("midwait_mem", rd, 32'd0);

        // Back-to-back zero-wait traffic.
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            do_xfer(0, 1'b1, Base + 32'(4 * i), 32'(17 * (i + 1)), 0, rd, err, low, m_err, m_rd);
        end
        for (int i = 0; i < 4; i++) begin
            do_xfer(0, 1'b0, Base + 32'(4 * i), 32'h0, 0, rd, err, low, m_err, m_rd);
            check($sformatf("b2b_read%0d", i), rd, 32'(17 * (i + 1)));
        end
        check("b2b_cycles", cyc - t0, 32'd16);
        check("b2b_wr_count", 32'(wr_count[0]), 32'd4);
        check("b2b_rd_count", 32'(rd_count[0]), 32'd4);

        // Randomised traffic against the model.
        for (int n = 0; n < 120; n++) begin
            d   = int'($urandom_range(0, 2));
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel <= 6) begin
                a = Base + 4 * (($urandom_range(0, 7) == 0) ? 32'd255 : $urandom_range(0, 15));
            end else if (sel == 7) begin
                a = Base + 4 * $urandom_range(256, 300);
            end else if (sel == 8) begin
                a = Base + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            end else begin
                a = Base - 4 * $urandom_range(1, 50);
            end
            do_xfer(d, wr, a, wd, 0, rd, err, low, m_err, m_rd);
            check($sformatf("rnd%0d_pslverr", n), 32'(err), 32'(m_err));
            check($sformatf("rnd%0d_wait", n), low, ws_of(d));
            if (!wr) check($sformatf("rnd%0d_prdata", n), rd, m_rd);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("final%0d_wr_count", i), 32'(wr_count[i]), exp_wr[i]);
            check($sformatf("final%0d_rd_count", i), 32'(rd_count[i]), exp_rd[i]);
            check($sformatf("final%0d_proto", i), 32'(proto_err[i]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
